// File: rtl/ex_pkg.sv
// Shared encodings for the execute unit: op classes, sub-types, functs and FSM states.
// The decoder and reservation stations import this package as well.
package ex_pkg;

  typedef enum logic [2:0] {
    ClsNone = 3'd0,
    ClsR    = 3'd1,
    ClsI    = 3'd2,
    ClsRsv  = 3'd3,
    ClsB    = 3'd4,
    ClsU    = 3'd5,
    ClsJ    = 3'd6,
    ClsM    = 3'd7
  } op_class_e;

  localparam logic [2:0] SubIAlu    = 3'd2;
  localparam logic [2:0] SubIJalr   = 3'd3;
  localparam logic [2:0] SubIFence  = 3'd4;
  localparam logic [2:0] SubISystem = 3'd5;
  localparam logic [2:0] SubULui    = 3'd1;
  localparam logic [2:0] SubUAuipc  = 3'd2;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSll  = 4'd1,
    AluSlt  = 4'd2,
    AluSltu = 4'd3,
    AluXor  = 4'd4,
    AluSrl  = 4'd5,
    AluOr   = 4'd6,
    AluAnd  = 4'd7,
    AluSub  = 4'd8,
    AluSra  = 4'd13
  } alu_op_e;

  localparam logic [2:0] BrEq  = 3'd0;
  localparam logic [2:0] BrNe  = 3'd1;
  localparam logic [2:0] BrLt  = 3'd4;
  localparam logic [2:0] BrGe  = 3'd5;
  localparam logic [2:0] BrLtu = 3'd6;
  localparam logic [2:0] BrGeu = 3'd7;

  localparam logic [2:0] MMul    = 3'd0;
  localparam logic [2:0] MMulh   = 3'd1;
  localparam logic [2:0] MMulhsu = 3'd2;
  localparam logic [2:0] MMulhu  = 3'd3;
  localparam logic [2:0] MDiv    = 3'd4;
  localparam logic [2:0] MDivu   = 3'd5;
  localparam logic [2:0] MRem    = 3'd6;
  localparam logic [2:0] MRemu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StHold = 2'd3
  } ex_state_e;

  // funct3[2] splits multiplies (0) from divides/remainders (1).
  function automatic logic m_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider: XLEN iterations on magnitudes, sign fix-up on the final step.
// done_o is asserted during the last iteration with the finished quotient/remainder.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, dvnd_q;
  logic            neg_quo_q, neg_rem_q, div0_q;

  logic [XLEN:0]   rem_sh, diff;
  logic            fits;
  logic [XLEN-1:0] rem_n, quo_n;
  logic            a_neg, b_neg;

  assign a_neg = signed_i & dividend_i[XLEN-1];
  assign b_neg = signed_i & divisor_i[XLEN-1];

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    fits   = ~diff[XLEN];
    rem_n  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n  = {quo_q[XLEN-2:0], fits};
  end

  assign done_o = busy_q && (cnt_q == CntW'(XLEN - 1));
  // Divide-by-zero overrides the natural restoring result.
  assign quot_o = div0_q ? '1 : (neg_quo_q ? -quo_n : quo_n);
  assign rem_o  = div0_q ? dvnd_q : (neg_rem_q ? -rem_n : rem_n);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (en_i) begin
      if (kill_i) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (start_i) begin
        busy_q    <= 1'b1;
        cnt_q     <= '0;
        rem_q     <= '0;
        quo_q     <= a_neg ? -dividend_i : dividend_i;
        dvsr_q    <= b_neg ? -divisor_i : divisor_i;
        dvnd_q    <= dividend_i;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= (divisor_i == '0);
      end else if (busy_q) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 1'b1;
        if (done_o) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ex_unit.sv
// Single-issue execute unit: ALU, branches, jumps, U-type, and optional RV32M.
// One op in flight; the result is held until the CDB takes it.
module ex_unit
  import ex_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned Q_WIDTH = 5,
  parameter int unsigned EN_M    = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9:0]         in_op,
  input  logic [XLEN-1:0]    in_v1,
  input  logic [XLEN-1:0]    in_v2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [Q_WIDTH-1:0] in_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_v,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_jump,
  output logic [Q_WIDTH-1:0] out_q
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned CntW = 2;

  ex_state_e          state_q;
  logic [CntW-1:0]    mul_cnt_q;
  logic               out_valid_q, out_jump_q;
  logic [XLEN-1:0]    out_v_q, out_pc_q;
  logic [Q_WIDTH-1:0] out_q_q;
  logic [XLEN:0]      mul_a_q, mul_b_q;
  logic [2:0]         m_f3_q;

  op_class_e       cls;
  logic [2:0]      sub;
  logic            is_m, accept, taken;
  logic [XLEN-1:0] pc4, res_v, res_pc;
  logic            res_jump;

  assign cls      = op_class_e'(in_op[9:7]);
  assign sub      = in_op[6:4];
  assign pc4      = in_pc + XLEN'(4);
  assign is_m     = (cls == ClsM) && (EN_M != 0);
  assign in_ready = (state_q == StIdle) && !rst_in;
  assign accept   = in_valid && in_ready && rdy_in;

  function automatic logic [XLEN-1:0] alu(input logic [3:0] fn, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [ShW-1:0] sh;
    sh = b[ShW-1:0];
    case (alu_op_e'(fn))
      AluAdd:  alu = a + b;
      AluSll:  alu = a << sh;
      AluSlt:  alu = XLEN'($signed(a) < $signed(b));
      AluSltu: alu = XLEN'(a < b);
      AluXor:  alu = a ^ b;
      AluSrl:  alu = a >> sh;
      AluOr:   alu = a | b;
      AluAnd:  alu = a & b;
      AluSub:  alu = a - b;
      AluSra:  alu = $unsigned($signed(a) >>> sh);
      default: alu = '0;
    endcase
  endfunction

  always_comb begin
    taken = 1'b0;
    case (in_op[2:0])
      BrEq:    taken = (in_v1 == in_v2);
      BrNe:    taken = (in_v1 != in_v2);
      BrLt:    taken = ($signed(in_v1) < $signed(in_v2));
      BrGe:    taken = ($signed(in_v1) >= $signed(in_v2));
      BrLtu:   taken = (in_v1 < in_v2);
      BrGeu:   taken = (in_v1 >= in_v2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res_v    = '0;
    res_pc   = pc4;
    res_jump = 1'b0;
    case (cls)
      ClsR: res_v = alu(in_op[3:0], in_v1, in_v2);
      ClsI: begin
        if (sub == SubIAlu) begin
          res_v = alu(in_op[3:0], in_v1, in_imm);
        end else if (sub == SubIJalr) begin
          res_v    = pc4;
          res_pc   = (in_v1 + in_imm) & ~XLEN'(1);
          res_jump = 1'b1;
        end
      end
      ClsB: begin
        res_jump = taken;
        if (taken) res_pc = in_pc + in_imm;
      end
      ClsU: begin
        if (sub == SubULui) res_v = in_imm;
        else if (sub == SubUAuipc) res_v = in_pc + in_imm;
      end
      ClsJ: begin
        res_v    = pc4;
        res_pc   = in_pc + in_imm;
        res_jump = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiplier: operands come straight from the inputs on accept, from registers afterwards.
  logic            in_sa, in_sb;
  logic [XLEN:0]   a_in, b_in, mul_a, mul_b;
  logic [2:0]      mul_f3;
  logic [2*XLEN-1:0] mul_pa, mul_pb, prod;
  logic [XLEN-1:0] mul_res;

  assign in_sa  = (in_op[2:0] == MMulh) || (in_op[2:0] == MMulhsu);
  assign in_sb  = (in_op[2:0] == MMulh);
  assign a_in   = {in_sa & in_v1[XLEN-1], in_v1};
  assign b_in   = {in_sb & in_v2[XLEN-1], in_v2};
  assign mul_a  = (state_q == StIdle) ? a_in : mul_a_q;
  assign mul_b  = (state_q == StIdle) ? b_in : mul_b_q;
  assign mul_f3 = (state_q == StIdle) ? in_op[2:0] : m_f3_q;
  assign mul_pa = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
  assign mul_pb = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
  assign prod   = mul_pa * mul_pb;
  assign mul_res = (mul_f3 == MMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic            div_start, div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  assign div_start = accept && is_m && m_is_div(in_op[2:0]) && !flush_in;

  ex_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .en_i       (rdy_in),
    .kill_i     (flush_in),
    .start_i    (div_start),
    .signed_i   (~in_op[0]),
    .dividend_i (in_v1),
    .divisor_i  (in_v2),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      mul_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_v_q     <= '0;
      out_pc_q    <= '0;
      out_jump_q  <= 1'b0;
      out_q_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      m_f3_q      <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        mul_cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              out_q_q <= in_q;
              if (is_m) begin
                out_pc_q   <= pc4;
                out_jump_q <= 1'b0;
                m_f3_q     <= in_op[2:0];
                mul_a_q    <= a_in;
                mul_b_q    <= b_in;
                if (m_is_div(in_op[2:0])) begin
                  state_q <= StDiv;
                end else if (MUL_LAT <= 1) begin
                  out_v_q     <= mul_res;
                  out_valid_q <= 1'b1;
                  state_q     <= StHold;
                end else begin
                  mul_cnt_q <= CntW'(MUL_LAT - 2);
                  state_q   <= StMul;
                end
              end else begin
                out_v_q     <= res_v;
                out_pc_q    <= res_pc;
                out_jump_q  <= res_jump;
                out_valid_q <= 1'b1;
                state_q     <= StHold;
              end
            end
          end
          StMul: begin
            if (mul_cnt_q == '0) begin
              out_v_q     <= mul_res;
              out_valid_q <= 1'b1;
              state_q     <= StHold;
            end else begin
              mul_cnt_q <= mul_cnt_q - 1'b1;
            end
          end
          StDiv: begin
            if (div_done) begin
              out_v_q     <= m_f3_q[1] ? div_rem : div_quot;
              out_valid_q <= 1'b1;
              state_q     <= StHold;
            end
          end
          StHold: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_v     = out_v_q;
  assign out_pc    = out_pc_q;
  assign out_jump  = out_jump_q;
  assign out_q     = out_q_q;

endmodule

// File: tb/tb_ex_unit.sv
// Directed and randomized bench for ex_unit, checked against an arithmetic reference model.
module tb_ex_unit;

  localparam int XLEN = 32;
  localparam int QW   = 5;
  localparam int ML   = 2;

  logic            clk = 1'b0;
  logic            rst_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready, out_jump;
  logic [9:0]      in_op;
  logic [31:0]     in_v1, in_v2, in_imm, in_pc, out_v, out_pc;
  logic [QW-1:0]   in_q, out_q;

  int tests = 0;
  int fails = 0;
  bit rdy_seen;
  bit vld_seen;

  always #5 clk = ~clk;

  ex_unit #(
    .XLEN    (XLEN),
    .Q_WIDTH (QW),
    .EN_M    (1),
    .MUL_LAT (ML)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_v1     (in_v1),
    .in_v2     (in_v2),
    .in_imm    (in_imm),
    .in_pc     (in_pc),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_v     (out_v),
    .out_pc    (out_pc),
    .out_jump  (out_jump),
    .out_q     (out_q)
  );

  typedef struct {
    logic [31:0] v;
    logic [31:0] npc;
    logic        jump;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_m(input int fn, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (fn)
      0:       return a + b;
      1:       return a << sh;
      2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:       return (a < b) ? 32'd1 : 32'd0;
      4:       return a ^ b;
      5:       return a >> sh;
      6:       return a | b;
      7:       return a & b;
      8:       return a - b;
      13:      return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc);
    exp_t r;
    int cls, sub, fn, f3;
    longint sa, sb, p, q;
    logic [63:0] ua, ub, up;
    logic tk;
    cls = int'(op[9:7]);
    sub = int'(op[6:4]);
    fn  = int'(op[3:0]);
    f3  = int'(op[2:0]);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    r.v = 32'd0;
    r.npc = pc + 32'd4;
    r.jump = 1'b0;
    r.lat = 1;
    case (cls)
      1: r.v = alu_m(fn, a, b);
      2: begin
        if (sub == 2) r.v = alu_m(fn, a, imm);
        else if (sub == 3) begin
          r.v = pc + 32'd4;
          r.npc = (a + imm) & ~32'd1;
          r.jump = 1'b1;
        end
      end
      4: begin
        case (f3)
          0:       tk = (a == b);
          1:       tk = (a != b);
          4:       tk = (sa < sb);
          5:       tk = (sa >= sb);
          6:       tk = (a < b);
          7:       tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) begin
          r.npc = pc + imm;
          r.jump = 1'b1;
        end
      end
      5: begin
        if (sub == 1) r.v = imm;
        else if (sub == 2) r.v = pc + imm;
      end
      6: begin
        r.v = pc + 32'd4;
        r.npc = pc + imm;
        r.jump = 1'b1;
      end
      7: begin
        r.lat = (f3 >= 4) ? XLEN + 1 : ML;
        case (f3)
          0: begin p = sa * sb; r.v = p[31:0]; end
          1: begin p = sa * sb; r.v = p[63:32]; end
          2: begin p = sa * longint'(ub); r.v = p[63:32]; end
          3: begin up = ua * ub; r.v = up[63:32]; end
          4: begin
            if (b == 0) r.v = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r.v = a;
            else begin q = sa / sb; r.v = q[31:0]; end
          end
          5: r.v = (b == 0) ? 32'hFFFF_FFFF : a / b;
          6: begin
            if (b == 0) r.v = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r.v = 32'd0;
            else begin q = sa % sb; r.v = q[31:0]; end
          end
          default: r.v = (b == 0) ? a : a % b;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [9:0] rand_op();
    logic [2:0] c, s;
    logic [3:0] f;
    c = 3'($urandom_range(7));
    s = 3'($urandom_range(7));
    f = 4'($urandom_range(15));
    if (c == 3'd1 || c == 3'd6 || c == 3'd7) s = 3'd0;
    if (c == 3'd2) s = 3'($urandom_range(6, 1));
    if (c == 3'd4 || c == 3'd7) f[3] = 1'b0;
    return {c, s, f};
  endfunction

  task automatic issue(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [QW-1:0] q);
    in_op = op; in_v1 = a; in_v2 = b; in_imm = imm; in_pc = pc; in_q = q;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs so results must come from registered state.
    in_op = 10'($urandom); in_v1 = $urandom; in_v2 = $urandom;
    in_imm = $urandom; in_pc = $urandom; in_q = QW'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [9:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [QW-1:0] q, input int stall, input int hold);
    exp_t e;
    int   lat;
    e = model(op, a, b, imm, pc);
    chk({tag, " in_ready idle"}, in_ready, 1);
    issue(op, a, b, imm, pc, q);
    if (stall > 0) begin
      rdy_in = 1'b0;
      repeat (stall) @(posedge clk);
      #1 rdy_in = 1'b1;
    end
    lat = 1 + stall;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, e.lat + stall);
    chk({tag, " in_ready busy"}, rdy_seen, 0);
    for (int i = 0; i <= hold; i++) begin
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " out_v"}, out_v, e.v);
      chk({tag, " out_pc"}, out_pc, e.npc);
      chk({tag, " out_jump"}, out_jump, e.jump);
      chk({tag, " out_q"}, out_q, q);
      chk({tag, " in_ready hold"}, in_ready, 0);
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, out_valid, 0);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    vld_seen = 1'b0;
    repeat (cycles) begin
      if (out_valid) vld_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk(tag, vld_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0; in_q = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_v", out_v, 0);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_jump", out_jump, 0);
    chk("rst out_q", out_q, 0);
    rst_in = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_op("add", {3'd1, 3'd0, 4'd0}, 32'd5, -32'sd3, 32'd0, 32'h40, 5'd7, 0, 0);
    run_op("blt", {3'd4, 3'd0, 4'd4}, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd3, 0, 0);
    run_op("bltu", {3'd4, 3'd0, 4'd6}, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd4, 0, 0);
    run_op("jalr", {3'd2, 3'd3, 4'd0}, 32'h1001, 32'd0, 32'h4, 32'h200, 5'd9, 0, 0);
    run_op("jal", {3'd6, 3'd0, 4'd0}, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h300, 5'd10, 0, 0);
    run_op("div ovf", {3'd7, 3'd0, 4'd4}, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h10, 5'd1, 0, 0);
    run_op("rem x/0", {3'd7, 3'd0, 4'd6}, 32'd17, 32'd0, 0, 32'h14, 5'd2, 0, 0);
    run_op("divu x/0", {3'd7, 3'd0, 4'd5}, 32'd17, 32'd0, 0, 32'h18, 5'd5, 0, 0);
    run_op("mulh", {3'd7, 3'd0, 4'd1}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h1c, 5'd6, 0, 0);
    run_op("mulhu", {3'd7, 3'd0, 4'd3}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h20, 5'd8, 0, 0);
    run_op("hold sub", {3'd1, 3'd0, 4'd8}, 32'd100, 32'd58, 0, 32'h24, 5'd11, 0, 5);
    run_op("mul stall", {3'd7, 3'd0, 4'd0}, 32'd1234, 32'hFFFF_FFFD, 0, 32'h28, 5'd12, 3, 0);

    // Flush in the middle of a divide drops the result.
    issue({3'd7, 3'd0, 4'd4}, 32'd1000, 32'd7, 0, 32'h30, 5'd13);
    repeat (10) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    watch_no_valid("flush no result", 40);

    // Reset in the middle of a divide.
    issue({3'd7, 3'd0, 4'd5}, 32'd999, 32'd3, 0, 32'h34, 5'd14);
    repeat (5) @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_pc", out_pc, 0);
    chk("midrst out_q", out_q, 0);
    chk("midrst in_ready", in_ready, 0);
    rst_in = 1'b0;
    #1;
    chk("midrst idle", in_ready, 1);
    watch_no_valid("midrst no result", 40);

    for (int n = 0; n < 60; n++) begin
      run_op("rand", rand_op(), pick_val(), pick_val(), pick_val(), $urandom & 32'hFFFF_FFFC,
             QW'($urandom), 0, int'($urandom_range(2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
